// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and parity-mode constants
// common to the transmitter and receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  localparam int PARITY_EVEN = 0;
  localparam int PARITY_ODD  = 1;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer for an asynchronous input. The flops reset
// to 1 so that an idle-high serial line stays quiet across reset.
module sync_2ff (
  input  logic clk,
  input  logic RSTn,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receiver: start/data/parity/stop framing with mid-bit sampling, parallel
// output with a one-cycle valid strobe, and parity/framing error flags.
module uart_rx_fsm
  import uart_pkg::*;
#(
  parameter int divisor     = 10,
  parameter int rx_num_bits = 8,
  parameter int parity      = PARITY_EVEN
) (
  input  logic       clk,
  input  logic       RSTn,
  input  logic       RX,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err
);

  localparam logic [31:0] HALF_M1  = 32'(divisor / 2 - 1);
  localparam logic [31:0] BIT_M1   = 32'(divisor - 1);
  localparam logic [3:0]  LAST_BIT = 4'(rx_num_bits - 1);
  localparam logic [7:0]  MASK     = 8'((1 << rx_num_bits) - 1);

  rx_state_t   r_state;
  rx_state_t   w_next;
  logic        w_rx_s;
  logic        r_rx_prev;
  logic        w_fall;
  logic [31:0] r_baud_cnt;
  logic [3:0]  r_bit_cnt;
  logic [7:0]  r_shift;
  logic        r_par_bit;
  logic        w_half;
  logic        w_tick;
  logic [7:0]  w_data;
  logic [7:0]  r_data_out;
  logic        r_data_valid;
  logic        r_parity_err;
  logic        r_frame_err;

  function automatic logic f_parity_exp(input logic [7:0] d);
    return (parity == PARITY_ODD) ? ~^d : ^d;
  endfunction

  sync_2ff u_sync (
    .clk  (clk),
    .RSTn (RSTn),
    .i_d  (RX),
    .o_q  (w_rx_s)
  );

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) r_rx_prev <= 1'b1;
    else       r_rx_prev <= w_rx_s;
  end

  assign w_fall = r_rx_prev & ~w_rx_s;
  assign w_half = (r_baud_cnt == HALF_M1);
  assign w_tick = (r_baud_cnt == BIT_M1);
  assign w_data = r_shift & MASK;

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_fall) w_next = START;
      START:   if (w_half) w_next = w_rx_s ? IDLE : DATA;
      DATA:    if (w_tick && (r_bit_cnt == LAST_BIT)) w_next = PARITY;
      PARITY:  if (w_tick) w_next = STOP;
      STOP:    if (w_tick) w_next = w_rx_s ? IDLE : BREAK;
      BREAK:   if (w_rx_s) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      r_baud_cnt   <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_par_bit    <= 1'b0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      case (r_state)
        START: begin
          if (w_half) begin
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
          end else begin
            r_baud_cnt <= r_baud_cnt + 32'd1;
          end
        end
        DATA: begin
          if (w_tick) begin
            r_shift[r_bit_cnt[2:0]] <= w_rx_s;
            r_bit_cnt               <= r_bit_cnt + 4'd1;
            r_baud_cnt              <= '0;
          end else begin
            r_baud_cnt <= r_baud_cnt + 32'd1;
          end
        end
        PARITY: begin
          if (w_tick) begin
            r_par_bit  <= w_rx_s;
            r_baud_cnt <= '0;
          end else begin
            r_baud_cnt <= r_baud_cnt + 32'd1;
          end
        end
        STOP: begin
          if (w_tick) begin
            r_data_out   <= w_data;
            r_parity_err <= r_par_bit ^ f_parity_exp(w_data);
            r_frame_err  <= ~w_rx_s;
            r_data_valid <= 1'b1;
            r_baud_cnt   <= '0;
          end else begin
            r_baud_cnt <= r_baud_cnt + 32'd1;
          end
        end
        default: begin
          // IDLE and BREAK keep the counters parked at zero.
          r_baud_cnt <= '0;
          r_bit_cnt  <= '0;
        end
      endcase
    end
  end

  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Bench for uart_rx_fsm: a default 8-bit/even/divisor-10 receiver and a
// 5-bit/odd/divisor-16 receiver, driven with directed and random frames.
module tb_uart_rx_fsm;

  logic       clk = 1'b0;
  logic       RSTn;
  logic       rx0, rx1;
  logic [7:0] data0, data1;
  logic       dv0, dv1, pe0, pe1, fe0, fe1;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } rec_t;

  int   checks   = 0;
  int   failures = 0;
  int   cnt0 = 0, cnt1 = 0;
  int   dbl0 = 0, dbl1 = 0;
  logic prev0 = 1'b0, prev1 = 1'b0;
  rec_t last0, last1;

  always #5 clk = ~clk;

  uart_rx_fsm dut0 (
    .clk        (clk),
    .RSTn       (RSTn),
    .RX         (rx0),
    .data_out   (data0),
    .data_valid (dv0),
    .parity_err (pe0),
    .frame_err  (fe0)
  );

  uart_rx_fsm #(.divisor(16), .rx_num_bits(5), .parity(1)) dut1 (
    .clk        (clk),
    .RSTn       (RSTn),
    .RX         (rx1),
    .data_out   (data1),
    .data_valid (dv1),
    .parity_err (pe1),
    .frame_err  (fe1)
  );

  // Record every completed frame shortly after the clock edge that produced it.
  always @(posedge clk) begin
    #1;
    if (dv0) begin
      cnt0++;
      last0 = '{data0, pe0, fe0};
    end
    if (dv1) begin
      cnt1++;
      last1 = '{data1, pe1, fe1};
    end
    if (dv0 && prev0) dbl0++;
    if (dv1 && prev1) dbl1++;
    prev0 = dv0;
    prev1 = dv1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Parity bit a correct transmitter would send for the first nb bits of d.
  function automatic logic exp_par(input logic [7:0] d, input int nb, input logic odd);
    int ones = 0;
    for (int i = 0; i < nb; i++) ones += int'(d[i]);
    return logic'(ones % 2) ^ odd;
  endfunction

  function automatic logic [7:0] model_data(input logic [7:0] d, input int nb);
    logic [7:0] r = '0;
    for (int i = 0; i < nb; i++) r[i] = d[i];
    return r;
  endfunction

  task automatic drive(input int which, input logic b, input int n);
    if (which == 0) rx0 = b;
    else            rx1 = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input int which, input logic [7:0] d, input logic pb,
                            input logic sb, input int nb, input int div);
    drive(which, 1'b0, div);
    for (int i = 0; i < nb; i++) drive(which, d[i], div);
    drive(which, pb, div);
    drive(which, sb, div);
  endtask

  // Check that exactly one new frame arrived and that it matches the model.
  task automatic expect_frame(input string tag, input int which, input int n_before,
                              input logic [7:0] d, input logic pb, input logic sb,
                              input int nb, input logic odd);
    rec_t r;
    int   c;
    c = (which == 0) ? cnt0 : cnt1;
    r = (which == 0) ? last0 : last1;
    chk({tag, "_count"}, 32'(c), 32'(n_before + 1));
    chk({tag, "_data"},  32'(r.d),  32'(model_data(d, nb)));
    chk({tag, "_perr"},  32'(r.pe), 32'(pb != exp_par(d, nb, odd)));
    chk({tag, "_ferr"},  32'(r.fe), 32'(!sb));
  endtask

  initial begin
    int         n;
    logic [7:0] d;
    logic       pb, flip;

    RSTn = 1'b0;
    rx0  = 1'b1;
    rx1  = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_data0", 32'(data0), 32'h0);
    chk("rst_dv0",   32'(dv0),   32'h0);
    chk("rst_pe0",   32'(pe0),   32'h0);
    chk("rst_fe0",   32'(fe0),   32'h0);
    chk("rst_data1", 32'(data1), 32'h0);
    RSTn = 1'b1;
    repeat (5) @(negedge clk);

    // Good frame
    n = cnt0;
    send_frame(0, 8'hA5, exp_par(8'hA5, 8, 1'b0), 1'b1, 8, 10);
    expect_frame("good", 0, n, 8'hA5, exp_par(8'hA5, 8, 1'b0), 1'b1, 8, 1'b0);
    drive(0, 1'b1, 10);

    // Short low glitch must not produce a frame
    n = cnt0;
    drive(0, 1'b0, 3);
    drive(0, 1'b1, 15);
    chk("glitch_count", 32'(cnt0), 32'(n));
    chk("glitch_hold",  32'(data0), 32'hA5);
    n = cnt0;
    send_frame(0, 8'hC3, exp_par(8'hC3, 8, 1'b0), 1'b1, 8, 10);
    expect_frame("after_glitch", 0, n, 8'hC3, exp_par(8'hC3, 8, 1'b0), 1'b1, 8, 1'b0);
    drive(0, 1'b1, 10);

    // Parity error, then a good frame clears it
    n = cnt0;
    send_frame(0, 8'h3C, 1'b1, 1'b1, 8, 10);
    expect_frame("par_err", 0, n, 8'h3C, 1'b1, 1'b1, 8, 1'b0);
    drive(0, 1'b1, 10);
    n = cnt0;
    send_frame(0, 8'h5A, exp_par(8'h5A, 8, 1'b0), 1'b1, 8, 10);
    expect_frame("par_clear", 0, n, 8'h5A, exp_par(8'h5A, 8, 1'b0), 1'b1, 8, 1'b0);
    drive(0, 1'b1, 10);

    // Framing error with a held-low line, then recovery
    n = cnt0;
    send_frame(0, 8'h55, exp_par(8'h55, 8, 1'b0), 1'b0, 8, 10);
    expect_frame("frm_err", 0, n, 8'h55, exp_par(8'h55, 8, 1'b0), 1'b0, 8, 1'b0);
    drive(0, 1'b0, 30);
    chk("break_quiet", 32'(cnt0), 32'(n + 1));
    drive(0, 1'b1, 20);
    chk("break_idle", 32'(cnt0), 32'(n + 1));
    n = cnt0;
    send_frame(0, 8'h12, exp_par(8'h12, 8, 1'b0), 1'b1, 8, 10);
    expect_frame("frm_recover", 0, n, 8'h12, exp_par(8'h12, 8, 1'b0), 1'b1, 8, 1'b0);
    drive(0, 1'b1, 10);

    // Reset during data bit 3
    drive(0, 1'b0, 10);
    for (int i = 0; i < 3; i++) drive(0, 1'b1, 10);
    drive(0, 1'b1, 4);
    RSTn = 1'b0;
    rx0  = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_data0", 32'(data0), 32'h0);
    chk("midrst_dv0",   32'(dv0),   32'h0);
    chk("midrst_pe0",   32'(pe0),   32'h0);
    chk("midrst_fe0",   32'(fe0),   32'h0);
    RSTn = 1'b1;
    n = cnt0;
    drive(0, 1'b1, 20);
    chk("midrst_quiet", 32'(cnt0), 32'(n));
    send_frame(0, 8'h81, exp_par(8'h81, 8, 1'b0), 1'b1, 8, 10);
    drive(0, 1'b1, 10);
    expect_frame("midrst_after", 0, n, 8'h81, exp_par(8'h81, 8, 1'b0), 1'b1, 8, 1'b0);

    // Narrow odd-parity receiver, back-to-back frames
    drive(1, 1'b1, 5);
    n = cnt1;
    send_frame(1, 8'h1F, exp_par(8'h1F, 5, 1'b1), 1'b1, 5, 16);
    expect_frame("narrow_1f", 1, n, 8'h1F, exp_par(8'h1F, 5, 1'b1), 1'b1, 5, 1'b1);
    n = cnt1;
    send_frame(1, 8'h0A, exp_par(8'h0A, 5, 1'b1), 1'b1, 5, 16);
    expect_frame("narrow_0a", 1, n, 8'h0A, exp_par(8'h0A, 5, 1'b1), 1'b1, 5, 1'b1);
    chk("narrow_upper", 32'(data1[7:5]), 32'h0);
    drive(1, 1'b1, 16);

    // Random frames on both receivers
    for (int k = 0; k < 10; k++) begin
      d    = 8'($urandom);
      flip = ($urandom_range(0, 3) == 0);
      pb   = exp_par(d, 8, 1'b0) ^ flip;
      n    = cnt0;
      send_frame(0, d, pb, 1'b1, 8, 10);
      expect_frame("rand8", 0, n, d, pb, 1'b1, 8, 1'b0);
      drive(0, 1'b1, $urandom_range(0, 20));
    end
    for (int k = 0; k < 6; k++) begin
      d    = 8'($urandom);
      flip = ($urandom_range(0, 3) == 0);
      pb   = exp_par(d, 5, 1'b1) ^ flip;
      n    = cnt1;
      send_frame(1, d, pb, 1'b1, 5, 16);
      expect_frame("rand5", 1, n, d, pb, 1'b1, 5, 1'b1);
      drive(1, 1'b1, $urandom_range(0, 30));
    end

    repeat (5) @(negedge clk);
    chk("single_pulse0", 32'(dbl0), 32'h0);
    chk("single_pulse1", 32'(dbl1), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
